regs_wb_arbiter: RTL

//  Shares the single write port of the 32x32 register file between two writeback

---
 rtl/regs_wb_arbiter_pkg.sv | 17 +
 rtl/regs_wb_arbiter_if.sv | 30 +++
 rtl/regs_wb_arbiter_scoreboard.sv | 48 ++++
 rtl/regs_wb_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/regs_wb_arbiter_pkg.sv
// Shared register-file definitions for the writeback arbiter slice.
package regs_pkg;

  localparam int REG_AW = 5;
  localparam int REG_DW = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_MEM = 1'b1
  } req_sel_t;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [REG_DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regs_wb_arbiter_if.sv
// Writeback request handshakes from the ALU (EX) and load unit (MEM).
interface regs_wb_arbiter_if
  import regs_pkg::*;
#(
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
);

  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready
  );

endinterface

// File: rtl/regs_wb_arbiter_scoreboard.sv
// Pending-write scoreboard for registers 1..2**AW-1 with two hazard lookup ports.
module regs_scoreboard
  import regs_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_addr,
  input  logic          L_S,
  input  logic [AW-1:0] Wt_addr,
  input  logic [AW-1:0] R_addr_A,
  input  logic [AW-1:0] R_addr_B,
  output logic          hazard_A,
  output logic          hazard_B
);

  localparam int unsigned NREG = 2 ** AW;

  logic [NREG-1:1] pending;
  logic [NREG-1:0] pend_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending <= '0;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        // A new reservation wins over the retiring write to the same register.
        if (rsv_valid && rsv_addr == AW'(r))
          pending[r] <= 1'b1;
        else if (L_S && Wt_addr == AW'(r))
          pending[r] <= 1'b0;
      end
    end
  end

  // Bit 0 is tied low so r0 lookups never flag.
  assign pend_full = {pending, 1'b0};

  always_comb begin
    hazard_A = rst && (R_addr_A != '0) &&
               (pend_full[R_addr_A] || (L_S && Wt_addr == R_addr_A));
    hazard_B = rst && (R_addr_B != '0) &&
               (pend_full[R_addr_B] || (L_S && Wt_addr == R_addr_B));
  end

endmodule

// File: rtl/regs_wb_arbiter.sv
// Round-robin writeback arbiter sharing the Regs write port between ALU and MEM.
module regs_wb_arbiter
  import regs_pkg::*;
#(
  parameter int AW         = REG_AW,
  parameter int DW         = REG_DW,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_hold,
  regs_wb_arbiter_if.slave     wb,
  input  logic                 rsv_valid,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [AW-1:0]        R_addr_A,
  input  logic [AW-1:0]        R_addr_B,
  output logic                 hazard_A,
  output logic                 hazard_B,
  output logic [AW-1:0]        Wt_addr,
  output logic [DW-1:0]        Wt_data,
  output logic                 L_S
);

  req_sel_t prio_q, prio_d;
  logic     alu_gnt, mem_gnt, both_valid;

  always_comb begin
    both_valid = wb.alu_valid && wb.mem_valid;
    alu_gnt    = 1'b0;
    mem_gnt    = 1'b0;
    prio_d     = prio_q;
    if (rst && !wb_hold) begin
      alu_gnt = wb.alu_valid && (!wb.mem_valid || prio_q == REQ_ALU);
      mem_gnt = wb.mem_valid && (!wb.alu_valid || prio_q == REQ_MEM);
    end
    // Contention hands priority to the loser; fixed mode pins it on ALU.
    if (FIXED_PRIO)
      prio_d = REQ_ALU;
    else if (both_valid && alu_gnt)
      prio_d = REQ_MEM;
    else if (both_valid && mem_gnt)
      prio_d = REQ_ALU;
    wb.alu_ready = alu_gnt;
    wb.mem_ready = mem_gnt;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      prio_q <= REQ_ALU;
    else
      prio_q <= prio_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      Wt_addr <= '0;
      Wt_data <= '0;
      L_S     <= 1'b0;
    end else if (alu_gnt) begin
      Wt_addr <= wb.alu_addr;
      Wt_data <= wb.alu_data;
      L_S     <= (wb.alu_addr != '0);
    end else if (mem_gnt) begin
      Wt_addr <= wb.mem_addr;
      Wt_data <= wb.mem_data;
      L_S     <= (wb.mem_addr != '0);
    end else begin
      L_S     <= 1'b0;
    end
  end

  regs_scoreboard #(.AW(AW)) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .L_S       (L_S),
    .Wt_addr   (Wt_addr),
    .R_addr_A  (R_addr_A),
    .R_addr_B  (R_addr_B),
    .hazard_A  (hazard_A),
    .hazard_B  (hazard_B)
  );

endmodule
